// File: rtl/dtable_ctrl.sv
// D-table controller: snoops CPU data writes, queues dirty block indices and
// sets their bits in the table RAM by read-modify-write; also serves bus reads.
module dtable_ctrl #(
    parameter logic [15:0] DMEM_BASE  = 16'h0200,
    parameter logic [15:0] DMEM_SIZE  = 16'h4000,
    parameter int unsigned BLK_SIZE   = 128,
    parameter logic [13:0] CTRL_ADDR  = 14'h00C8,
    parameter logic [13:0] TBL_ADDR   = 14'h00C9,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned BLK_SH    = $clog2(BLK_SIZE),
    localparam int unsigned WORDS     = 32'(DMEM_SIZE) / BLK_SIZE / 16,
    localparam int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             mclk,
    input  logic             puc_rst,
    input  logic [13:0]      per_addr,
    input  logic [15:0]      per_din,
    input  logic             per_en,
    input  logic [1:0]       per_we,
    output logic [15:0]      per_dout,
    input  logic [15:0]      dmem_addr,
    input  logic             dmem_wen,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [15:0]      tbl_wdata,
    output logic             tbl_we,
    input  logic [15:0]      tbl_rdata,
    output logic             busy,
    output logic             ovf
);
    localparam int unsigned EV_W  = IDX_W + 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, CLR} state_t;

    state_t            state_q, state_d;
    logic [EV_W-1:0]   idx_q, idx_d;
    logic [15:0]       wbuf_q, wbuf_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [EV_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              clr_pend_q, clr_pend_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              hit_q;
    logic [15:0]       ctrl_dout_q, ctrl_dout_d;

    logic              ev_valid, push, pop, flush, drop, fifo_full;
    logic [EV_W-1:0]   ev_idx;
    logic              per_rd_tbl, per_rd_ctrl, per_wr_ctrl;
    logic [IDX_W-1:0]  per_off;
    logic              unused_ok;

    assign ev_valid = dmem_wen && (dmem_addr >= DMEM_BASE) &&
                      ({1'b0, dmem_addr} <= ({1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE} - 17'd1));
    assign ev_idx   = EV_W'((dmem_addr - DMEM_BASE) >> BLK_SH);

    assign per_rd_tbl  = per_en && (per_we == 2'b00) && (per_addr >= TBL_ADDR) &&
                         (32'(per_addr) < (32'(TBL_ADDR) + WORDS));
    assign per_rd_ctrl = per_en && (per_we == 2'b00) && (per_addr == CTRL_ADDR);
    assign per_wr_ctrl = per_en && (per_we != 2'b00) && (per_addr == CTRL_ADDR);
    assign per_off     = IDX_W'(per_addr - TBL_ADDR);
    assign unused_ok   = ^{per_din[15:3], per_din[1]};

    assign fifo_full = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wbuf_d  = wbuf_q;
        ptr_d   = ptr_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d = CLR;
                    flush   = 1'b1;
                    ptr_d   = '0;
                end else if (cnt_q != '0) begin
                    pop     = 1'b1;
                    idx_d   = fifo_q[rp_q];
                    state_d = RD;
                end
            end
            RD:  if (!per_rd_tbl) state_d = CAP;
            CAP: begin
                wbuf_d  = tbl_rdata | (16'h1 << idx_q[3:0]);
                state_d = WR;
            end
            WR:  if (!per_rd_tbl) state_d = IDLE;
            CLR: begin
                if (!per_rd_tbl) begin
                    if (ptr_q == IDX_W'(WORDS - 1)) state_d = IDLE;
                    else                            ptr_d   = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush empties the FIFO first, so an event in the same cycle still lands.
        drop = ev_valid && fifo_full && !pop && !flush;
        push = ev_valid && !drop;
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (flush) begin
            rp_d  = wp_q;
            cnt_d = '0;
        end else if (pop) begin
            rp_d  = rp_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
        if (push) begin
            wp_d  = wp_q + 1'b1;
            cnt_d = cnt_d + 1'b1;
        end

        clr_pend_d  = (clr_pend_q && !flush) || (per_wr_ctrl && per_din[0]);
        ovf_d       = drop || (ovf_q && !(per_wr_ctrl && per_din[2]));
        busy_d      = (state_d != IDLE) || (cnt_d != '0) || clr_pend_d;
        ctrl_dout_d = per_rd_ctrl ? {13'b0, ovf_q, busy_q, clr_pend_q || (state_q == CLR)} : '0;
    end

    // The RAM port is combinational so a bus read can take it in its own cycle.
    always_comb begin
        tbl_addr  = '0;
        tbl_wdata = '0;
        tbl_we    = 1'b0;
        if (per_rd_tbl) begin
            tbl_addr = per_off;
        end else begin
            case (state_q)
                RD:  tbl_addr = idx_q[EV_W-1:4];
                WR: begin
                    tbl_addr  = idx_q[EV_W-1:4];
                    tbl_wdata = wbuf_q;
                    tbl_we    = 1'b1;
                end
                CLR: begin
                    tbl_addr = ptr_q;
                    tbl_we   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wbuf_q      <= '0;
            ptr_q       <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            clr_pend_q  <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            ctrl_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wbuf_q      <= wbuf_d;
            ptr_q       <= ptr_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            clr_pend_q  <= clr_pend_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            hit_q       <= per_rd_tbl;
            ctrl_dout_q <= ctrl_dout_d;
            if (push) fifo_q[wp_q] <= ev_idx;
        end
    end

    assign per_dout = hit_q ? tbl_rdata : ctrl_dout_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_dtable_ctrl.sv
// Bench for dtable_ctrl: directed steps plus randomized writes checked against
// a word-array model of the D-table and a queue model of the event FIFO.
module tb_dtable_ctrl;
    localparam logic [15:0] BASE  = 16'h0200;
    localparam logic [15:0] SIZE  = 16'h4000;
    localparam int unsigned WORDS = 8;
    localparam logic [13:0] CTRL  = 14'h00C8;
    localparam logic [13:0] TBL   = 14'h00C9;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] dmem_addr;
    logic        dmem_wen;
    logic [2:0]  tbl_addr;
    logic [15:0] tbl_wdata;
    logic        tbl_we;
    logic [15:0] tbl_rdata;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    dtable_ctrl #(
        .DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .BLK_SIZE(128),
        .CTRL_ADDR(CTRL), .TBL_ADDR(TBL), .FIFO_DEPTH(4)
    ) dut (
        .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_we(tbl_we), .tbl_rdata(tbl_rdata),
        .busy(busy), .ovf(ovf)
    );

    always #5 mclk = ~mclk;

    // Table RAM: synchronous single port, read data one cycle after address.
    logic [15:0] mem [WORDS];
    logic [15:0] rd_q;
    always @(posedge mclk) begin
        if (tbl_we) mem[tbl_addr] <= tbl_wdata;
        rd_q <= mem[tbl_addr];
    end
    assign tbl_rdata = rd_q;

    logic [15:0] ref_tbl [WORDS];

    function automatic bit in_range(input logic [15:0] a);
        return (32'(a) >= 32'(BASE)) && (32'(a) < 32'(BASE) + 32'(SIZE));
    endfunction

    function automatic void ref_mark(input logic [15:0] a);
        int unsigned blk;
        if (in_range(a)) begin
            blk = (32'(a) - 32'(BASE)) / 128;
            ref_tbl[blk / 16][blk % 16] = 1'b1;
        end
    endfunction

    task automatic tick;
        @(posedge mclk); #1;
    endtask

    task automatic mid;
        @(negedge mclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic per_rd(input logic [13:0] a, output logic [15:0] d);
        per_en = 1'b1; per_we = 2'b00; per_addr = a;
        tick;
        per_en = 1'b0; per_addr = '0;
        mid;
        d = per_dout;
        tick;
    endtask

    task automatic per_wr(input logic [13:0] a, input logic [15:0] v);
        per_en = 1'b1; per_we = 2'b11; per_addr = a; per_din = v;
        tick;
        per_en = 1'b0; per_we = 2'b00; per_addr = '0; per_din = '0;
    endtask

    task automatic dmem_wr(input logic [15:0] a);
        dmem_addr = a; dmem_wen = 1'b1;
        tick;
        dmem_wen = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        mid;
        while (busy !== 1'b0 && n < 300) begin
            tick; mid; n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] a;
        int n;
        int q[$];
        int next_free;
        int had;
        bit popping;
        bit exp_ovf;

        for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
        puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = '0;
        dmem_addr = '0; dmem_wen = 1'b0;
        tick; tick; tick;
        puc_rst = 1'b0;
        mid;
        check("rst_per_dout",  {16'b0, per_dout}, 32'd0);
        check("rst_tbl_addr",  {29'b0, tbl_addr}, 32'd0);
        check("rst_tbl_wdata", {16'b0, tbl_wdata}, 32'd0);
        check("rst_tbl_we",    {31'b0, tbl_we}, 32'd0);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        check("rst_ovf",       {31'b0, ovf}, 32'd0);
        tick;

        // Clear-all sweep with a CTRL read in the middle
        per_wr(CTRL, 16'h0001);
        n = 0;
        mid;
        while (tbl_we !== 1'b1 && n < 6) begin tick; mid; n++; end
        check("clr_start", {31'b0, tbl_we}, 32'd1);
        for (int k = 0; k < WORDS; k++) begin
            if (k > 0) begin
                tick;
                if (k == 1) begin per_en = 1'b1; per_we = 2'b00; per_addr = CTRL; end
                if (k == 2) begin per_en = 1'b0; per_addr = '0; end
                mid;
            end
            check("clr_we",    {31'b0, tbl_we}, 32'd1);
            check("clr_addr",  {29'b0, tbl_addr}, 32'(k));
            check("clr_wdata", {16'b0, tbl_wdata}, 32'd0);
            if (k == 2) check("clr_ctrl_rd", {16'b0, per_dout}, 32'h0003);
        end
        tick; mid;
        check("clr_busy_end", {31'b0, busy}, 32'd0);
        check("clr_we_end", {31'b0, tbl_we}, 32'd0);
        tick;
        for (int i = 0; i < WORDS; i++) ref_tbl[i] = '0;

        // Single event: idx 3 -> word 0 bit 3, write strobe in cycle 4
        dmem_wr(16'h0385);
        mid; check("ev_busy", {31'b0, busy}, 32'd1);
        tick; mid; check("ev_c2_we", {31'b0, tbl_we}, 32'd0);
        tick; tick; mid;
        check("ev_we",    {31'b0, tbl_we}, 32'd1);
        check("ev_addr",  {29'b0, tbl_addr}, 32'd0);
        check("ev_wdata", {16'b0, tbl_wdata}, 32'h0008);
        tick; mid; check("ev_busy_end", {31'b0, busy}, 32'd0);
        tick;
        ref_mark(16'h0385);

        // Out-of-range writes just below and just above the tracked window
        for (int j = 0; j < 2; j++) begin
            dmem_wr(j == 0 ? 16'h01FE : 16'h4200);
            for (int c = 0; c < 5; c++) begin
                mid; check("oor_quiet", {30'b0, busy, tbl_we}, 32'd0);
                tick;
            end
        end

        // Randomized writes (spaced so nothing drops) with random stolen reads
        for (int e = 0; e < 40; e++) begin
            if (e == 0)      a = 16'h0200;
            else if (e == 1) a = 16'h41FF;
            else if (e == 2) a = 16'h01FF;
            else if (e == 3) a = 16'h4200;
            else if ($urandom_range(0, 9) < 7) a = 16'(32'(BASE) + $urandom_range(0, 32'(SIZE) - 1));
            else if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 16'h01FF));
            else a = 16'($urandom_range(16'h4200, 16'hFFFF));
            dmem_wr(a);
            ref_mark(a);
            n = $urandom_range(6, 10);
            for (int g = 1; g < n; g++) begin
                if ($urandom_range(0, 7) == 0) begin
                    per_en = 1'b1; per_we = 2'b00; per_addr = 14'(TBL + $urandom_range(0, WORDS - 1));
                end else begin
                    per_en = 1'b0; per_addr = '0;
                end
                tick;
            end
            per_en = 1'b0; per_addr = '0;
        end
        wait_idle("rnd_idle");
        mid; check("rnd_ovf", {31'b0, ovf}, 32'd0);
        tick;
        for (int w = 0; w < WORDS; w++) begin
            per_rd(14'(TBL + w), d);
            check("rnd_word", {16'b0, d}, {16'b0, ref_tbl[w]});
        end
        mid; check("idle_dout", {16'b0, per_dout}, 32'd0);
        tick;
        per_rd(14'h00C0, d);
        check("rd_outside_lo", {16'b0, d}, 32'd0);
        per_rd(14'(TBL + WORDS), d);
        check("rd_outside_hi", {16'b0, d}, 32'd0);
        per_wr(TBL, 16'hFFFF);
        per_rd(TBL, d);
        check("tbl_wr_ignored", {16'b0, d}, {16'b0, ref_tbl[0]});

        // Port contention: read of word 1 while the FSM sits in RD for idx 40
        dmem_wr(16'h1600);
        tick;
        per_en = 1'b1; per_we = 2'b00; per_addr = TBL + 14'd1;
        mid;
        check("cont_addr_rd", {29'b0, tbl_addr}, 32'd1);
        check("cont_we_rd",   {31'b0, tbl_we}, 32'd0);
        tick;
        per_en = 1'b0; per_addr = '0;
        mid;
        check("cont_dout", {16'b0, per_dout}, {16'b0, ref_tbl[1]});
        check("cont_rd_hold", {29'b0, tbl_addr}, 32'd2);
        tick; tick; mid;
        check("cont_we",    {31'b0, tbl_we}, 32'd1);
        check("cont_addr",  {29'b0, tbl_addr}, 32'd2);
        check("cont_wdata", {16'b0, tbl_wdata}, {16'b0, ref_tbl[2] | 16'h0100});
        tick;
        ref_mark(16'h1600);
        wait_idle("cont_idle");

        // Overflow: 7 back-to-back writes; queue model with 4-cycle service
        q.delete(); next_free = 0; exp_ovf = 1'b0;
        for (int c = 0; c < 7; c++) begin
            had = q.size();
            popping = (c >= next_free) && (had > 0);
            if (had == 4 && !popping) exp_ovf = 1'b1;
            else q.push_back(48 + c);
            if (popping) begin
                void'(q.pop_front());
                next_free = c + 4;
            end
            if (!(had == 4 && !popping)) ref_mark(16'(32'(BASE) + (48 + c) * 128));
            dmem_addr = 16'(32'(BASE) + (48 + c) * 128); dmem_wen = 1'b1;
            tick;
        end
        dmem_wen = 1'b0;
        per_rd(CTRL, d);
        check("ovf_ctrl", {16'b0, d}, exp_ovf ? 32'h0006 : 32'h0002);
        mid; check("ovf_flag", {31'b0, ovf}, {31'b0, exp_ovf});
        tick;
        wait_idle("ovf_idle");
        per_rd(TBL + 14'd3, d);
        check("ovf_word3", {16'b0, d}, {16'b0, ref_tbl[3]});
        per_wr(CTRL, 16'h0004);
        per_rd(CTRL, d);
        check("ovf_cleared", {16'b0, d}, 32'd0);

        // Reset while in CAP with a second event still queued
        dmem_addr = 16'h0A00; dmem_wen = 1'b1;
        tick;
        dmem_addr = 16'h0A80;
        tick;
        dmem_wen = 1'b0;
        tick;
        puc_rst = 1'b1;
        tick;
        puc_rst = 1'b0;
        mid;
        check("rmw_rst_we",    {31'b0, tbl_we}, 32'd0);
        check("rmw_rst_addr",  {29'b0, tbl_addr}, 32'd0);
        check("rmw_rst_wdata", {16'b0, tbl_wdata}, 32'd0);
        check("rmw_rst_dout",  {16'b0, per_dout}, 32'd0);
        check("rmw_rst_busy",  {31'b0, busy}, 32'd0);
        check("rmw_rst_ovf",   {31'b0, ovf}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick; mid;
            check("rmw_rst_quiet", {30'b0, busy, tbl_we}, 32'd0);
        end
        tick;
        per_rd(TBL + 14'd1, d);
        check("rmw_rst_word1", {16'b0, d}, {16'b0, ref_tbl[1]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
